// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem port responder: word RAM plus MMIO TX FIFO, status, cycle counter
// Optional cycle counter at MMIO offset 0x2 is enabled by defining DMEM_CYCLE_COUNTER_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           fifo_buf [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           q_dmem_q, q_dmem_d;
  logic [31:0]           mmio_rdata;
  logic [31:0]           cycle_rdata;

  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            offset;
  logic                  full, empty, msb_sat;
  logic                  txd_wr, stat_wr, push, pop;
  logic                  unused_addr;

  assign is_mmio     = address_dmem[31];
  assign idx         = address_dmem[ADDR_WIDTH-1:0];
  assign offset      = address_dmem[3:0];
  assign unused_addr = ^address_dmem[30:ADDR_WIDTH];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign msb_sat = (count_q >= CW'(FIFO_DEPTH / 2));

  assign tx_valid = !empty;
  assign tx_data  = fifo_buf[rd_ptr_q];
  assign q_dmem   = q_dmem_q;

  // A pop at the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign pop     = tx_valid && tx_ready;
  assign txd_wr  = wren && is_mmio && (offset == 4'h0);
  assign stat_wr = wren && is_mmio && (offset == 4'h1);
  assign push    = txd_wr && (!full || pop);

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if (wren && is_mmio && (offset == 4'h2)) begin
      cycle_q <= data;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_rdata = cycle_q;
`else
  assign cycle_rdata = '0;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      4'h1:    mmio_rdata = {27'b0, ovf_q, full, empty, msb_sat, 1'b1};
      4'h2:    mmio_rdata = cycle_rdata;
      default: mmio_rdata = '0;
    endcase
  end

  always_comb begin
    q_dmem_d = mem[idx];
    if (is_mmio) begin
      q_dmem_d = mmio_rdata;
    end else if (wren) begin
      q_dmem_d = data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr) begin
      ovf_d = 1'b0;
    end else if (txd_wr && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // Storage arrays keep their contents across reset.
  always_ff @(posedge clock) begin
    if (wren && !is_mmio) begin
      mem[idx] <= data;
    end
    if (push) begin
      fifo_buf[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      q_dmem_q <= q_dmem_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
// Counter checks follow DMEM_CYCLE_COUNTER_EN.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks;
  int errors;

  localparam logic [31:0] TXD  = 32'h8000_0000;
  localparam logic [31:0] STAT = 32'h8000_0001;
  localparam logic [31:0] CYC  = 32'h8000_0002;

  dmem_responder #(.ADDR_WIDTH(12), .FIFO_DEPTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    address_dmem = a;
    data         = d;
    wren         = w;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] c_a;
    logic [31:0] c_b;
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    tx_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0);

    #3;
    chk("reset_q", q_dmem, 32'h0);
    chk("reset_valid", {31'b0, tx_valid}, 32'h0);
    tick();
    tick();
    reset = 1'b1;

    // RAM round trip, write-first and aliasing
    drive(32'd5, 32'h1234ABCD, 1'b1); tick();
    chk("ram_write_first", q_dmem, 32'h1234ABCD);
    drive(32'd5, 32'h0, 1'b0); tick();
    chk("ram_read", q_dmem, 32'h1234ABCD);
    drive(32'd5 + 32'd4096, 32'h0, 1'b0); tick();
    chk("ram_alias", q_dmem, 32'h1234ABCD);

    // Fill to overflow with the sink stalled
    for (int i = 1; i <= 9; i++) begin
      drive(TXD, i, 1'b1); tick();
    end
    drive(STAT, 32'h0, 1'b0); tick();
    chk("status_full_ovf", q_dmem, 32'h0000_001B);
    chk("head_after_fill", tx_data, 32'd1);
    chk("valid_after_fill", {31'b0, tx_valid}, 32'd1);
    drive(STAT, 32'h0, 1'b1); tick();
    drive(STAT, 32'h0, 1'b0); tick();
    chk("status_ovf_cleared", q_dmem, 32'h0000_000B);
    drive(TXD, 32'h0, 1'b0); tick();
    chk("txdata_reads_zero", q_dmem, 32'h0);
    drive(32'h8000_0007, 32'h0, 1'b0); tick();
    chk("unmapped_reads_zero", q_dmem, 32'h0);

    // Drain in order
    drive(32'h0, 32'h0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", tx_data, i);
      tick();
    end
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);

    // Partial refill, then drain again
    tx_ready = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      drive(TXD, i, 1'b1); tick();
    end
    drive(STAT, 32'h0, 1'b0); tick();
    chk("status_half", q_dmem, 32'h0000_0003);
    drive(32'h0, 32'h0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      chk("wrap_data", tx_data, i);
      tick();
    end
    chk("wrap_drained_valid", {31'b0, tx_valid}, 32'h0);

    // Full FIFO with simultaneous push and pop; write pointer crosses the wrap
    tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(TXD, 32'h21 + k, 1'b1); tick();
    end
    drive(STAT, 32'h0, 1'b0); tick();
    chk("status_full_again", q_dmem, 32'h0000_000B);
    tx_ready = 1'b1;
    drive(TXD, 32'h55, 1'b1); tick();
    tx_ready = 1'b0;
    drive(STAT, 32'h0, 1'b0); tick();
    chk("status_push_pop_full", q_dmem, 32'h0000_000B);
    chk("head_after_push_pop", tx_data, 32'h22);
    drive(32'h0, 32'h0, 1'b0);
    tx_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("push_pop_order", tx_data, 32'h22 + k);
      tick();
    end
    chk("push_pop_eighth", tx_data, 32'h55);
    tick();
    chk("push_pop_drained", {31'b0, tx_valid}, 32'h0);

    // Asynchronous reset in the middle of a drain
    tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(TXD, 32'h31 + k, 1'b1); tick();
    end
    drive(32'd5, 32'h0, 1'b0);
    tx_ready = 1'b1;
    tick();
    chk("pre_reset_q", q_dmem, 32'h1234ABCD);
    chk("pre_reset_head", tx_data, 32'h32);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_q", q_dmem, 32'h0);
    chk("async_reset_valid", {31'b0, tx_valid}, 32'h0);
    chk("async_reset_stale_head", tx_data, 32'h25);
    #2;
    reset = 1'b1;
    tx_ready = 1'b0;
    tick();
    chk("ram_kept_over_reset", q_dmem, 32'h1234ABCD);
    drive(STAT, 32'h0, 1'b0); tick();
    chk("status_after_reset", q_dmem, 32'h0000_0005);

`ifdef DMEM_CYCLE_COUNTER_EN
    drive(CYC, 32'h0, 1'b0); tick();
    c_a = q_dmem;
    repeat (10) tick();
    c_b = q_dmem;
    chk("cycle_delta", c_b - c_a, 32'd10);
    drive(CYC, 32'hFFFF_FFFE, 1'b1); tick();
    drive(CYC, 32'h0, 1'b0); tick();
    chk("cycle_load", q_dmem, 32'hFFFF_FFFE);
    tick();
    chk("cycle_max", q_dmem, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", q_dmem, 32'h0);
`else
    c_a = 32'h0;
    c_b = 32'h0;
    drive(CYC, 32'h1234, 1'b1); tick();
    drive(CYC, 32'h0, 1'b0); tick();
    chk("cycle_absent", q_dmem + c_a + c_b, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
